// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill path: address field layout,
// refill FSM encoding and a saturating counter helper.
package cache_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int SET_BITS = 6;
    localparam int OFF_BITS = 2;
    localparam int TAG_W    = ADDR_W - SET_BITS - OFF_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } refill_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [SET_BITS-1:0] set_idx;
        logic [OFF_BITS-1:0] off;
    } addr_fields_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_refill_controller_lru_table.sv
// One LRU bit per set; the stored bit names the way to evict next.
module lru_table #(
    parameter int SET_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_BITS-1:0] rd_set,
    output logic                rd_bit,
    input  logic                wr_en,
    input  logic [SET_BITS-1:0] wr_set,
    input  logic                wr_bit
);

    localparam int DEPTH = 1 << SET_BITS;

    logic [DEPTH-1:0] bits_q;
    logic [DEPTH-1:0] bits_d;

    // Next-state for the bit array: single write port.
    always_comb begin
        bits_d = bits_q;
        if (wr_en) begin
            bits_d[wr_set] = wr_bit;
        end else begin
            bits_d = bits_q;
        end
    end

    // Bit array storage, cleared so every set starts with way 0 as victim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign rd_bit = bits_q[rd_set];

endmodule

// File: rtl/cache_refill_controller.sv
// Miss handler behind the set-associative cache: tracks 2-way LRU, stalls the
// address source on a miss, fetches the line and writes it into the victim way.
module cache_refill_controller #(
    parameter  int ADDR_W   = cache_pkg::ADDR_W,
    parameter  int DATA_W   = cache_pkg::DATA_W,
    parameter  int SET_BITS = cache_pkg::SET_BITS,
    parameter  int OFF_BITS = cache_pkg::OFF_BITS,
    localparam int TAG_W    = ADDR_W - SET_BITS - OFF_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lookup_valid,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic                hit_in,
    input  logic                hit_way,
    output logic                stall_out,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                fill_we,
    output logic                fill_way,
    output logic [SET_BITS-1:0] fill_set,
    output logic [OFF_BITS-1:0] fill_off,
    output logic [DATA_W-1:0]   fill_data,
    output logic                fill_done,
    output logic [TAG_W-1:0]    fill_tag,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);

    import cache_pkg::*;

    refill_state_e       state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic                victim_q, victim_d;
    logic [OFF_BITS-1:0] beat_q, beat_d;
    logic [15:0]         hit_cnt_q, hit_cnt_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]    in_tag_s;
    logic [SET_BITS-1:0] in_set_s;
    logic                lru_rd_s;
    logic                lru_we_s;
    logic [SET_BITS-1:0] lru_wset_s;
    logic                lru_wbit_s;
    logic                unused_off_s;

    assign in_tag_s     = addr_in[ADDR_W-1 -: TAG_W];
    assign in_set_s     = addr_in[OFF_BITS +: SET_BITS];
    assign unused_off_s = ^addr_in[OFF_BITS-1:0];

    lru_table #(.SET_BITS(SET_BITS)) u_lru (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_set (in_set_s),
        .rd_bit (lru_rd_s),
        .wr_en  (lru_we_s),
        .wr_set (lru_wset_s),
        .wr_bit (lru_wbit_s)
    );

    // Refill FSM next-state; hit and fill LRU updates are exclusive by state.
    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        set_d      = set_q;
        victim_d   = victim_q;
        beat_d     = beat_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        lru_we_s   = 1'b0;
        lru_wset_s = '0;
        lru_wbit_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lookup_valid && hit_in) begin
                    hit_cnt_d  = sat_inc16(hit_cnt_q);
                    lru_we_s   = 1'b1;
                    lru_wset_s = in_set_s;
                    lru_wbit_s = ~hit_way;
                end else if (lookup_valid) begin
                    tag_d      = in_tag_s;
                    set_d      = in_set_s;
                    victim_d   = lru_rd_s;
                    miss_cnt_d = sat_inc16(miss_cnt_q);
                    state_d    = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_FILL: begin
                if (mem_rsp_valid) begin
                    beat_d = beat_q + {{(OFF_BITS-1){1'b0}}, 1'b1};
                    if (beat_q == {OFF_BITS{1'b1}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_DONE: begin
                lru_we_s   = 1'b1;
                lru_wset_s = set_q;
                lru_wbit_s = ~victim_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All controller state, cleared asynchronously (an interrupted fill is abandoned).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tag_q      <= '0;
            set_q      <= '0;
            victim_q   <= 1'b0;
            beat_q     <= '0;
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            set_q      <= set_d;
            victim_q   <= victim_d;
            beat_q     <= beat_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Memory request and cache write port, decoded from state; zero when inactive.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        fill_we       = 1'b0;
        fill_way      = 1'b0;
        fill_set      = '0;
        fill_off      = '0;
        fill_data     = '0;
        fill_done     = 1'b0;
        fill_tag      = '0;
        case (state_q)
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_q, set_q, {OFF_BITS{1'b0}}};
            end
            S_FILL: begin
                fill_we   = mem_rsp_valid;
                fill_way  = victim_q;
                fill_set  = set_q;
                fill_off  = beat_q;
                fill_data = mem_rsp_valid ? mem_rsp_data : '0;
            end
            S_DONE: begin
                fill_done = 1'b1;
                fill_tag  = tag_q;
                fill_way  = victim_q;
                fill_set  = set_q;
            end
            default: begin
                mem_req_valid = 1'b0;
            end
        endcase
    end

    // The missing cycle itself must hold the pointer, hence the combinational term.
    assign stall_out  = (state_q != S_IDLE) | (lookup_valid & ~hit_in);
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboard bench for cache_refill_controller: stimulus queues expected
// requests/fill beats/fill completions, a negedge monitor pops and compares.
module tb_cache_refill_controller;

    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [15:0] addr_in = 16'h0000;
    logic        hit_in = 1'b0;
    logic        hit_way = 1'b0;
    logic        stall_out;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        fill_we;
    logic        fill_way;
    logic [5:0]  fill_set;
    logic [1:0]  fill_off;
    logic [31:0] fill_data;
    logic        fill_done;
    logic [7:0]  fill_tag;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [15:0] req_q[$];
    logic [40:0] fill_q[$];
    logic [14:0] done_q[$];

    cache_refill_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_valid  (lookup_valid),
        .addr_in       (addr_in),
        .hit_in        (hit_in),
        .hit_way       (hit_way),
        .stall_out     (stall_out),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_we       (fill_we),
        .fill_way      (fill_way),
        .fill_set      (fill_set),
        .fill_off      (fill_off),
        .fill_data     (fill_data),
        .fill_done     (fill_done),
        .fill_tag      (fill_tag),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output seen with nothing expected", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) unexpected("req");
                else chk("req_addr", 64'(mem_req_addr), 64'(req_q.pop_front()));
            end
            if (fill_we) begin
                if (fill_q.size() == 0) unexpected("fill_we");
                else chk("fill_beat", 64'({fill_way, fill_set, fill_off, fill_data}), 64'(fill_q.pop_front()));
            end
            if (fill_done) begin
                if (done_q.size() == 0) unexpected("fill_done");
                else chk("fill_done", 64'({fill_tag, fill_way, fill_set}), 64'(done_q.pop_front()));
            end
        end
    end

    function automatic logic [15:0] mk_addr(input logic [7:0] tag, input logic [5:0] set_idx);
        addr_fields_t f;
        f.tag     = tag;
        f.set_idx = set_idx;
        f.off     = 2'b00;
        return f;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ctrl"}, 64'({stall_out, mem_req_valid, fill_we, fill_way, fill_done}), 64'd0);
        chk({tag, "_bus"}, 64'({mem_req_addr, fill_set, fill_off, fill_tag}), 64'd0);
        chk({tag, "_data"}, 64'(fill_data), 64'd0);
        chk({tag, "_cnt"}, 64'({hit_count, miss_count}), 64'd0);
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic hit(input logic [15:0] addr, input logic way);
        lookup_valid = 1'b1; addr_in = addr; hit_in = 1'b1; hit_way = way;
        exp_hits++;
        @(negedge clk); chk("stall_on_hit", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        lookup_valid = 1'b0; hit_in = 1'b0;
        @(negedge clk); chk("hit_count", 64'(hit_count), 64'(exp_hits));
        @(posedge clk); #1;
    endtask

    task automatic refill(input logic [15:0] addr, input logic way, input int rdy_wait,
                          input int gap, input logic [31:0] base);
        logic [15:0] line_a;
        logic [7:0]  tag;
        logic [5:0]  set_idx;
        line_a  = {addr[15:2], 2'b00};
        tag     = addr[15:8];
        set_idx = addr[7:2];
        lookup_valid = 1'b1; addr_in = addr; hit_in = 1'b0; hit_way = 1'b0;
        mem_req_ready = (rdy_wait == 0);
        req_q.push_back(line_a);
        exp_misses++;
        @(negedge clk); chk("stall_miss_cycle", 64'(stall_out), 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < rdy_wait; i++) begin
            lookup_valid = 1'b1; hit_in = 1'b1;
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_0000;
            @(negedge clk);
            chk("req_valid_hold", 64'(mem_req_valid), 64'd1);
            chk("req_addr_hold", 64'(mem_req_addr), 64'(line_a));
            @(posedge clk); #1;
        end
        lookup_valid = 1'b0; hit_in = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", 64'(mem_req_valid), 64'd1);
        chk("stall_req", 64'(stall_out), 64'd1);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b != 0) begin
                for (int g = 0; g < gap; g++) begin
                    mem_rsp_valid = 1'b0;
                    @(negedge clk);
                    chk("stall_gap", 64'(stall_out), 64'd1);
                    chk("no_we_gap", 64'(fill_we), 64'd0);
                    @(posedge clk); #1;
                end
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = base + 32'(b);
            fill_q.push_back({way, set_idx, 2'(b), base + 32'(b)});
            if (b == 3) done_q.push_back({tag, way, set_idx});
            @(negedge clk);
            chk("stall_fill", 64'(stall_out), 64'd1);
            chk("no_done_in_fill", 64'(fill_done), 64'd0);
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", 64'(fill_done), 64'd1);
        chk("stall_done", 64'(stall_out), 64'd1);
        chk("miss_count", 64'(miss_count), 64'(exp_misses));
        chk("hit_count_frozen", 64'(hit_count), 64'(exp_hits));
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); check_idle("in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); check_idle("after_reset");
        @(posedge clk); #1;

        // Cold miss at 0x0148 (tag 01, set 12), then the replayed lookup hits
        refill(16'h0148, 1'b0, 0, 0, 32'h0000_00A0);
        hit(16'h0148, 1'b0);
        // Set 0x12 now names way 1
        refill(mk_addr(8'h02, 6'h12), 1'b1, 0, 0, 32'h0000_00B8);
        hit(16'h0248, 1'b1);

        // Hit way 0 in set 5, next miss fills way 1, following miss fills way 0
        hit(16'h0314, 1'b0);
        refill(16'h0414, 1'b1, 0, 0, 32'h0000_00B0);
        // Backpressure 3 cycles, 2-cycle beat gaps, ignored lookups and beats in REQ
        refill(16'h0514, 1'b0, 3, 2, 32'h0000_00C0);

        // Hit counter saturation
        lookup_valid = 1'b1; addr_in = 16'h0314; hit_in = 1'b1; hit_way = 1'b0;
        repeat (65534 - exp_hits) @(posedge clk);
        #1;
        lookup_valid = 1'b0; hit_in = 1'b0;
        @(negedge clk); chk("hit_count_fffe", 64'(hit_count), 64'hFFFE);
        @(posedge clk); #1;
        lookup_valid = 1'b1; hit_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        lookup_valid = 1'b0; hit_in = 1'b0;
        @(negedge clk);
        chk("hit_count_sat", 64'(hit_count), 64'hFFFF);
        chk("miss_count_unchanged", 64'(miss_count), 64'(exp_misses));
        @(posedge clk); #1;

        // Reset during FILL after 2 beats (set 5 currently names way 1)
        lookup_valid = 1'b1; addr_in = 16'h0614; hit_in = 1'b0; mem_req_ready = 1'b1;
        req_q.push_back(16'h0614);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'h0000_00E0 + 32'(b);
            fill_q.push_back({1'b1, 6'h05, 2'(b), 32'h0000_00E0 + 32'(b)});
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        #1;
        check_idle("mid_fill_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); check_idle("post_mid_reset");
        @(posedge clk); #1;
        // Fresh refill: way 0 after reset, offsets restart at 0
        refill(16'h0614, 1'b0, 0, 0, 32'h0000_00D0);
        hit(16'h0614, 1'b0);

        repeat (2) @(posedge clk);
        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("fill_q_drained", 64'(fill_q.size()), 64'd0);
        chk("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_controller.md
# cache_refill_controller

Miss-handling stage directly downstream of `cache_set_associative`. It consumes the cache's per-cycle lookup result, tracks 2-way LRU state per set, and on a miss stalls the address source and fetches the missing line from memory. It then writes the line into the victim way. It also keeps saturating hit and miss counters for the access log.

## Interface
Parameters:
- `ADDR_W`, 16, word address width.
- `DATA_W`, 32, data word width.
- `SET_BITS`, 6, set index width.
- `OFF_BITS`, 2, word-in-line offset width; line = 2**OFF_BITS words.
- `TAG_W`, ADDR_W-SET_BITS-OFF_BITS, derived, not overridable.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `lookup_valid` in 1 — the cache performed a lookup this cycle.
- `addr_in` in ADDR_W — address looked up; fields are {tag, set, offset}.
- `hit_in` in 1 — lookup hit.
- `hit_way` in 1 — way that hit; valid when `hit_in`.
- `stall_out` out 1 — hold the address pointer.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_addr` out ADDR_W — line-aligned read request.
- `mem_rsp_valid` in 1, `mem_rsp_data` in DATA_W — in-order response beats, offset 0 first.
- `fill_we` out 1, `fill_way` out 1, `fill_set` out SET_BITS, `fill_off` out OFF_BITS, `fill_data` out DATA_W — cache data write port.
- `fill_done` out 1, `fill_tag` out TAG_W — one-cycle pulse; write the tag and set the valid bit for {`fill_way`, `fill_set`}.
- `hit_count` out 16, `miss_count` out 16 — saturating counters.

## Operation
- **LRU array:** `lru[2**SET_BITS]`, 1 bit per set. The bit names the victim way.
- **FSM states:** IDLE, REQ, FILL, DONE.
- **IDLE:**
  - On `lookup_valid & hit_in`: `lru[set] <= ~hit_way`, and `hit_count` increments.
  - On `lookup_valid & ~hit_in`: latch the address and `victim = lru[set]`, increment `miss_count`, then go to REQ.
- **REQ:**
  - `mem_req_valid` = 1 and `mem_req_addr` = {tag, set, 0}.
  - Move to FILL on the cycle where `mem_req_ready` = 1. Valid stays high until that cycle, and the address is held stable.
- **FILL:**
  - Each `mem_rsp_valid` beat drives `fill_we` = 1 in the same cycle, with `fill_data` = `mem_rsp_data`, `fill_off` = beat counter, `fill_way` = victim, and `fill_set` = latched set.
  - The beat counter increments and wraps from 2**OFF_BITS-1 to 0; that wrap moves the FSM to DONE.
- **DONE:**
  - `fill_done` = 1 with `fill_tag`, `fill_way` and `fill_set`.
  - `lru[set] <= ~victim`, then go to IDLE.
- **stall_out** = (state != IDLE) | (`lookup_valid` & ~`hit_in`). It is combinational, so the cycle that misses never advances the pointer. The same address is looked up again after the refill and hits.
- **Ignored inputs:**
  - Lookups while not in IDLE: no counting, no LRU update.
  - `mem_rsp_valid` outside FILL: dropped.
- **Counters:** saturate at 16'hFFFF and never wrap.
- **Reset (including mid-refill):**
  - All outputs go to 0, the FSM to IDLE, every LRU bit to 0 (victim way 0), and both counters to 0.
  - A partially written line is left with its valid bit clear, because `fill_done` never fires.

## Timing
- `fill_we`, `fill_*` and `mem_req_*` are combinational from state and registers. `fill_we` and `fill_data` also pass `mem_rsp_valid` / `mem_rsp_data` straight through in FILL. `stall_out` additionally depends combinationally on `lookup_valid` and `hit_in`.
- Minimum miss penalty, with ready and all beats back-to-back:
  - Miss in cycle 0.
  - REQ handshake in cycle 1.
  - Beats in cycles 2-5.
  - DONE in cycle 6.
  - IDLE in cycle 7, where the repeated lookup hits.
  - `stall_out` is high in cycles 0-6.
- Hit path: zero added latency; `stall_out` = 0.
- A gap in `mem_rsp_valid` holds FILL and the beat counter.

## Structure
- **Package `cache_pkg`:**
  - ADDR_W, DATA_W, SET_BITS, OFF_BITS, TAG_W.
  - `refill_state_e` enum.
  - Address field typedef (`struct packed` {tag, set, off}).
- **Sub-module `lru_table`:**
  - Parameterised bit array with async reset to 0.
  - One read port (set) and one write port (set, bit).
  - A hit update and a fill update never coincide, because of the FSM exclusivity.

## Test plan
- **Reset state:** reset asserted then released → every output 0, counters 0, `lru` all 0.
- **Cold miss at address 16'h0148** (set 0x12, tag 0x01):
  - `mem_req_valid` in cycle 1 with `mem_req_addr` = 16'h0148.
  - Beats 0xA0..0xA3 produce four `fill_we` on way 0, offsets 0-3.
  - `fill_done` with `fill_tag` = 0x01; `lru[0x12]` = 1; `stall_out` high in cycles 0-6.
- **Hit then miss in the same set:**
  - Hit on set 0x05 way 0 → `lru[0x05]` = 1.
  - The next miss in set 0x05 fills way 1, then `lru[0x05]` = 0.
- **Backpressure and beat gaps:**
  - `mem_req_ready` low for 3 cycles → `mem_req_valid` and `mem_req_addr` stay stable.
  - 2-cycle gaps between beats → `fill_off` still runs 0,1,2,3, and `fill_done` comes one cycle after the last beat.
- **Reset during FILL** after 2 beats → `fill_done` never pulses, outputs go to 0, the FSM is in IDLE, and the next miss starts a fresh REQ.
- **Counter saturation:** 65,540 hits → `hit_count` = 16'hFFFF and `miss_count` unchanged.
